// File: rtl/puf_enc_pkg.sv
// Shared parameters and state type for the PUF cell-index encoder.
package puf_enc_pkg;

  localparam int unsigned WIDTH  = 128;
  localparam int unsigned IDX_W  = $clog2(WIDTH);
  localparam int unsigned SEG_W  = 32;
  localparam int unsigned NSEG   = WIDTH / SEG_W;
  localparam int unsigned OFF_W  = $clog2(SEG_W);
  // Upper index bits select the segment, lower bits are the in-segment offset.
  localparam int unsigned SEGI_W = IDX_W - OFF_W;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_e;

endpackage

// File: rtl/puf_prienc_seg.sv
// Lowest-set-bit encoder for one SEG_W-bit slice of the cell-enable mask.
module puf_prienc_seg
  import puf_enc_pkg::*;
(
  input  logic [SEG_W-1:0] i_Seg,
  output logic             o_Nz,
  output logic [OFF_W-1:0] o_Off
);

  // Scan from the top down so the lowest set bit wins the final assignment.
  always_comb begin
    o_Off = '0;
    for (int i = SEG_W - 1; i >= 0; i--) begin
      if (i_Seg[i]) begin
        o_Off = OFF_W'(i);
      end
    end
  end

  assign o_Nz = |i_Seg;

endmodule

// File: rtl/puf_enc128.sv
// Sequential multi-hot encoder: accepts a 128-bit cell-enable vector and emits
// the index of each set bit, lowest first, one index per output handshake.
module puf_enc128
  import puf_enc_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Vld,
  output logic             o_Rdy,
  input  logic [WIDTH-1:0] i_Q,
  output logic             o_Vld,
  input  logic             i_Rdy,
  output logic [IDX_W-1:0] o_Sel,
  output logic             o_Last,
  output logic             o_Zero,
  output logic [IDX_W:0]   o_Cnt
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic               zero_q, zero_d;
  logic [IDX_W:0]     cnt_q, cnt_d;

  logic [NSEG-1:0]    seg_nz;
  logic [OFF_W-1:0]   seg_off [NSEG];
  logic [SEGI_W-1:0]  seg_idx;
  logic [OFF_W-1:0]   low_off;
  logic [IDX_W-1:0]   low_idx;
  logic [WIDTH-1:0]   low_onehot;
  logic [WIDTH-1:0]   mask_clr;
  logic               last_beat;

  // Stage A: per-segment nonzero flag and lowest-bit offset.
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    puf_prienc_seg u_seg (
      .i_Seg (mask_q[g*SEG_W +: SEG_W]),
      .o_Nz  (seg_nz[g]),
      .o_Off (seg_off[g])
    );
  end

  // Stage B: pick the lowest nonzero segment and form the full index.
  always_comb begin
    seg_idx = '0;
    low_off = '0;
    for (int s = NSEG - 1; s >= 0; s--) begin
      if (seg_nz[s]) begin
        seg_idx = SEGI_W'(s);
        low_off = seg_off[s];
      end
    end
  end

  assign low_idx    = {seg_idx, low_off};
  assign low_onehot = WIDTH'(1) << low_idx;
  assign mask_clr   = mask_q & ~low_onehot;
  // Nothing left after removing the lowest bit means at most one bit was set.
  assign last_beat  = (mask_clr == '0);

  // Next-state and registered-only outputs; everything is gated by S_EMIT so idle shows zeros.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    o_Rdy   = 1'b0;
    o_Vld   = 1'b0;
    o_Sel   = '0;
    o_Last  = 1'b0;
    o_Zero  = 1'b0;
    o_Cnt   = '0;

    unique case (state_q)
      S_IDLE: begin
        o_Rdy = 1'b1;
        if (i_Vld) begin
          state_d = S_EMIT;
          mask_d  = i_Q;
          zero_d  = (i_Q == '0);
          // An all-zero vector reports a count of zero on its single beat.
          cnt_d   = (i_Q == '0) ? '0 : (IDX_W+1)'(1);
        end
      end
      S_EMIT: begin
        o_Vld  = 1'b1;
        o_Sel  = low_idx;
        o_Last = last_beat;
        o_Zero = zero_q;
        o_Cnt  = cnt_q;
        if (i_Rdy) begin
          if (last_beat) begin
            state_d = S_IDLE;
            mask_d  = '0;
          end else begin
            mask_d  = mask_clr;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_puf_enc128.sv
// Bench for puf_enc128: directed and random vectors against a bit-list model.
module tb_puf_enc128;

  logic         clk = 1'b0;
  logic         i_Rst;
  logic         i_Vld;
  logic         o_Rdy;
  logic [127:0] i_Q;
  logic         o_Vld;
  logic         i_Rdy;
  logic [6:0]   o_Sel;
  logic         o_Last;
  logic         o_Zero;
  logic [7:0]   o_Cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puf_enc128 dut (
    .i_Clk  (clk),
    .i_Rst  (i_Rst),
    .i_Vld  (i_Vld),
    .o_Rdy  (o_Rdy),
    .i_Q    (i_Q),
    .o_Vld  (o_Vld),
    .i_Rdy  (i_Rdy),
    .o_Sel  (o_Sel),
    .o_Last (o_Last),
    .o_Zero (o_Zero),
    .o_Cnt  (o_Cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int sel, input bit last, input bit zero,
                          input int cnt);
    chk({tag, ".vld"},  128'(o_Vld),  128'(1));
    chk({tag, ".rdy"},  128'(o_Rdy),  128'(0));
    chk({tag, ".sel"},  128'(o_Sel),  128'(sel));
    chk({tag, ".last"}, 128'(o_Last), 128'(last));
    chk({tag, ".zero"}, 128'(o_Zero), 128'(zero));
    chk({tag, ".cnt"},  128'(o_Cnt),  128'(cnt));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // rdy_pat bit j is i_Rdy on emit cycle j; beyond 32 cycles i_Rdy is held high.
  task automatic send_vec(input logic [127:0] v, input logic [31:0] rdy_pat, input string tag);
    int idx[$];
    int beats;
    int k;
    int cyc;
    bit r;
    for (int i = 0; i < 128; i++) if (v[i]) idx.push_back(i);
    beats = (idx.size() == 0) ? 1 : idx.size();
    chk({tag, ".accept_rdy"}, 128'(o_Rdy), 128'(1));
    i_Vld = 1'b1;
    i_Q   = v;
    @(negedge clk);
    k   = 0;
    cyc = 0;
    while (k < beats) begin
      if (idx.size() == 0) chk_beat($sformatf("%s.b%0d", tag, k), 0, 1'b1, 1'b1, 0);
      else chk_beat($sformatf("%s.b%0d", tag, k), idx[k], k == beats - 1, 1'b0, k + 1);
      r     = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
      i_Rdy = r;
      // Noise on the input side while emitting must be ignored.
      i_Vld = 1'($urandom_range(0, 1));
      i_Q   = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    i_Vld = 1'b0;
    i_Rdy = 1'b0;
    chk({tag, ".done_vld"}, 128'(o_Vld), 128'(0));
    chk({tag, ".done_rdy"}, 128'(o_Rdy), 128'(1));
  endtask

  initial begin
    logic [127:0] one;
    logic [127:0] v;
    int dens;
    one   = 128'd1;
    i_Rst = 1'b1;
    i_Vld = 1'b1;
    i_Q   = {$urandom(), $urandom(), $urandom(), $urandom()};
    i_Rdy = 1'b0;

    // Reset held two cycles with i_Vld high: idle outputs, no accept.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d.rdy", c),  128'(o_Rdy),  128'(1));
      chk($sformatf("rst%0d.vld", c),  128'(o_Vld),  128'(0));
      chk($sformatf("rst%0d.sel", c),  128'(o_Sel),  128'(0));
      chk($sformatf("rst%0d.last", c), 128'(o_Last), 128'(0));
      chk($sformatf("rst%0d.zero", c), 128'(o_Zero), 128'(0));
      chk($sformatf("rst%0d.cnt", c),  128'(o_Cnt),  128'(0));
    end
    i_Rst = 1'b0;
    i_Vld = 1'b0;
    @(negedge clk);
    chk("post_rst.rdy", 128'(o_Rdy), 128'(1));
    chk("post_rst.vld", 128'(o_Vld), 128'(0));

    // One-hot sweep, back-to-back accepts two cycles apart.
    for (int s = 0; s < 128; s++) send_vec(one << s, 32'hFFFF_FFFF, $sformatf("onehot%0d", s));

    // Multi-hot across segment boundaries.
    v = '0;
    v[3] = 1'b1; v[31] = 1'b1; v[32] = 1'b1; v[127] = 1'b1;
    send_vec(v, 32'hFFFF_FFFF, "multi");

    send_vec('0, 32'hFFFF_FFFF, "zero");

    // i_Rdy sequence 0,0,1,0,1 then high.
    send_vec(128'h5, 32'hFFFF_FFF4, "bp");

    // All-ones, reset while beat 40 is pending.
    chk("full.accept_rdy", 128'(o_Rdy), 128'(1));
    i_Vld = 1'b1;
    i_Q   = '1;
    @(negedge clk);
    i_Vld = 1'b0;
    for (int k = 0; k < 40; k++) begin
      chk_beat($sformatf("full.b%0d", k), k, 1'b0, 1'b0, k + 1);
      i_Rdy = 1'b1;
      @(negedge clk);
    end
    chk_beat("full.b40", 40, 1'b0, 1'b0, 41);
    i_Rdy = 1'b0;
    i_Rst = 1'b1;
    @(negedge clk);
    i_Rst = 1'b0;
    i_Rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("midrst%0d.vld", c), 128'(o_Vld), 128'(0));
      chk($sformatf("midrst%0d.cnt", c), 128'(o_Cnt), 128'(0));
      @(negedge clk);
    end
    i_Rdy = 1'b0;
    send_vec(128'h80, 32'hFFFF_FFFF, "after_rst");

    // Random vectors of varying density with random back-pressure.
    for (int t = 0; t < 40; t++) begin
      v    = {$urandom(), $urandom(), $urandom(), $urandom()};
      dens = $urandom_range(0, 5);
      for (int d = 0; d < dens; d++) v &= {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) v = '0;
      send_vec(v, $urandom(), $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
